// File: rtl/fifo_occ_ctrl_pkg.sv
// fifo_occ_ctrl_pkg: shared constants, step encoding and the up/down step cell.
// Rev 1.0
`default_nettype none

package fifo_occ_ctrl_pkg;

   localparam int CNT_W     = 4;
   localparam int MIN_DEPTH = 2;
   localparam int MAX_DEPTH = 8;
   localparam int MIN_AF    = 1;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'b00,
      STEP_UP   = 2'b01,
      STEP_DOWN = 2'b10
   } step_e;

   // 4-bit up/down step cell; callers never request UP at DEPTH or DOWN at 0.
   function automatic logic [CNT_W-1:0] step_apply(input logic [CNT_W-1:0] cnt,
                                                   input step_e step);
      logic [CNT_W-1:0] nxt;
      nxt = cnt;
      case (step)
         STEP_UP:   nxt = cnt + CNT_W'(1);
         STEP_DOWN: nxt = cnt - CNT_W'(1);
         default:   nxt = cnt;
      endcase
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit wrapping pointer with increment enable, sync clear, async reset.
// Rev 1.0
`default_nettype none

module fifo_ptr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr)
         ptr_d = '0;
      else if (inc)
         ptr_d = ptr_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo_occ_ctrl.sv
// fifo_occ_ctrl: push/pop acceptance, RAM pointers, occupancy count and status flags.
// Rev 1.0
`default_nettype none

module fifo_occ_ctrl
   import fifo_occ_ctrl_pkg::*;
#(
   parameter  int DEPTH    = 8,
   parameter  int AF_LEVEL = 6,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   output logic             wr_en,
   output logic             rd_en,
   output logic [AW-1:0]    wr_addr,
   output logic [AW-1:0]    rd_addr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             ovf_err,
   output logic             udf_err
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   step_e            step;

   // Flags derive only from the registered count, so a pop never frees a slot
   // for a push in the same cycle (and vice versa).
   assign full        = (count_q == CNT_W'(DEPTH));
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

   assign wr_en = push & ~full  & ~clr;
   assign rd_en = pop  & ~empty & ~clr;

   always_comb begin
      step = STEP_HOLD;
      if (wr_en && !rd_en)
         step = STEP_UP;
      else if (rd_en && !wr_en)
         step = STEP_DOWN;
   end

   always_comb begin
      count_d = step_apply(count_q, step);
      ovf_d   = ovf_q | (push & full);
      udf_d   = udf_q | (pop & empty);
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   fifo_ptr #(.W(AW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (wr_en),
      .ptr   (wr_addr)
   );

   fifo_ptr #(.W(AW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (rd_en),
      .ptr   (rd_addr)
   );

   assign count   = count_q;
   assign ovf_err = ovf_q;
   assign udf_err = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_occ_ctrl.sv
// tb_fifo_occ_ctrl: directed and random push/pop against an occupancy model.
// Rev 1.0
`default_nettype none

module tb_fifo_occ_ctrl;

   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic       clk = 1'b0;
   logic       rst_n, clr, push, pop;
   logic       wr_en, rd_en, full, empty, almost_full, ovf_err, udf_err;
   logic [2:0] wr_addr, rd_addr;
   logic [3:0] count;

   int checks   = 0;
   int failures = 0;

   // Model: occupancy as a plain integer, pointers as entry counters mod DEPTH.
   int m_cnt, m_wr, m_rd;
   bit m_ovf, m_udf;

   always #5 clk = ~clk;

   fifo_occ_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .push        (push),
      .pop         (pop),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .ovf_err     (ovf_err),
      .udf_err     (udf_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
   endtask

   function automatic bit exp_we();
      return push && (m_cnt != DEPTH) && !clr;
   endfunction

   function automatic bit exp_re();
      return pop && (m_cnt != 0) && !clr;
   endfunction

   task automatic check_all(input string ph);
      chk({ph, ".wr_en"},   32'(wr_en),       32'(exp_we()));
      chk({ph, ".rd_en"},   32'(rd_en),       32'(exp_re()));
      chk({ph, ".count"},   32'(count),       32'(m_cnt));
      chk({ph, ".wr_addr"}, 32'(wr_addr),     32'(m_wr));
      chk({ph, ".rd_addr"}, 32'(rd_addr),     32'(m_rd));
      chk({ph, ".full"},    32'(full),        32'(m_cnt == DEPTH));
      chk({ph, ".empty"},   32'(empty),       32'(m_cnt == 0));
      chk({ph, ".afull"},   32'(almost_full), 32'(m_cnt >= AF));
      chk({ph, ".ovf"},     32'(ovf_err),     32'(m_ovf));
      chk({ph, ".udf"},     32'(udf_err),     32'(m_udf));
      chk({ph, ".inv"},     32'(3'(wr_addr - rd_addr)), 32'(3'(count)));
   endtask

   // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
   task automatic step(input bit p, input bit q, input bit c, input string ph);
      bit we, re;
      push = p; pop = q; clr = c;
      #1;
      check_all(ph);
      we = exp_we();
      re = exp_re();
      @(posedge clk);
      if (c) begin
         m_reset();
      end else begin
         if (p && m_cnt == DEPTH) m_ovf = 1;
         if (q && m_cnt == 0)     m_udf = 1;
         m_cnt = m_cnt + int'(we) - int'(re);
         m_wr  = (m_wr + int'(we)) % DEPTH;
         m_rd  = (m_rd + int'(re)) % DEPTH;
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0;
      m_reset();
      #11;
      check_all("reset");
      rst_n = 1'b1;
      #5;

      // Async reset mid-cycle with a non-empty FIFO.
      repeat (5) step(1, 0, 0, "pre_rst");
      chk("pre_rst.count5", 32'(count), 32'd5);
      push = 0; pop = 0; clr = 0;
      rst_n = 1'b0;
      m_reset();
      #1;
      check_all("async_rst");
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill, overflow attempt.
      repeat (8) step(1, 0, 0, "fill");
      chk("fill.full",    32'(full),    32'd1);
      chk("fill.wr_wrap", 32'(wr_addr), 32'd0);
      step(1, 0, 0, "fill9");
      chk("fill9.ovf",   32'(ovf_err), 32'd1);
      chk("fill9.count", 32'(count),   32'd8);

      // Drain, underflow attempt.
      repeat (8) step(0, 1, 0, "drain");
      chk("drain.empty",   32'(empty),   32'd1);
      chk("drain.rd_wrap", 32'(rd_addr), 32'd0);
      step(0, 1, 0, "drain9");
      chk("drain9.udf", 32'(udf_err), 32'd1);

      // Simultaneous push+pop mid-range, then at full.
      step(0, 0, 1, "clr1");
      repeat (3) step(1, 0, 0, "to3");
      repeat (4) step(1, 1, 0, "both");
      chk("both.count", 32'(count),   32'd3);
      chk("both.wr",    32'(wr_addr), 32'd7);
      chk("both.rd",    32'(rd_addr), 32'd4);
      repeat (5) step(1, 0, 0, "to8");
      step(1, 1, 0, "both_full");
      chk("both_full.count", 32'(count),   32'd7);
      chk("both_full.ovf",   32'(ovf_err), 32'd1);

      // Clear has priority over push.
      step(1, 0, 0, "refill");
      step(0, 1, 0, "to7");
      step(0, 1, 0, "to6");
      step(0, 1, 0, "to5");
      chk("preclr.count", 32'(count), 32'd5);
      step(1, 0, 1, "clr_push");
      chk("clr.count", 32'(count),   32'd0);
      chk("clr.ovf",   32'(ovf_err), 32'd0);

      // Random traffic with occasional clear.
      for (int i = 0; i < 1000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 63) == 0), "rand");
      end
      check_all("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_occ_ctrl.md
Name: fifo_occ_ctrl

Overview:
Occupancy and pointer controller for a small synchronous FIFO; consumes the +1/-1/hold step produced by the 4-bit up/down step cell. Converts push/pop requests into accepted write/read strobes, RAM addresses, a registered 4-bit occupancy count, and status flags. Sits between the producer/consumer handshake and the FIFO storage array.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, 2..8, so occupancy 0..DEPTH fits 4 bits
AW, log2(DEPTH), address width; derived, not overridden
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of pointers, count and error flags
push  input  1  producer write request
pop  input  1  consumer read request
wr_en  output  1  push accepted this cycle (combinational)
rd_en  output  1  pop accepted this cycle (combinational)
wr_addr  output  AW  write pointer (registered)
rd_addr  output  AW  read pointer (registered)
count  output  4  current occupancy (registered)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
ovf_err  output  1  sticky: push while full
udf_err  output  1  sticky: pop while empty

Behaviour:
- Reset (rst_n low, asynchronous): wr_addr=0, rd_addr=0, count=0, ovf_err=0, udf_err=0; hence empty=1, full=0, almost_full=0. wr_en/rd_en follow from reset state (wr_en=push, rd_en=0).
- Acceptance: wr_en = push & ~full & ~clr; rd_en = pop & ~empty & ~clr. Flags come from registered count only; no combinational path from pop to wr_en (no push-through when full, no pop-through when empty).
- Count step per edge: up = wr_en & ~rd_en; down = rd_en & ~wr_en; both or neither -> hold. count_next = count+1 / count-1 / count; 4-bit unsigned; up never issued at DEPTH, down never at 0, so no wrap.
- Pointers: wr_addr increments on wr_en, rd_addr on rd_en; modulo DEPTH (natural AW-bit wrap, DEPTH-1 -> 0).
- Latency: count, pointers and flags reflect an accepted op one clock after the strobe.
- Simultaneous push+pop: 0<count<DEPTH -> both accepted, count holds, both pointers advance. Full -> only pop accepted, count-1, ovf_err sets. Empty -> only push accepted, count+1, udf_err sets.
- Errors: ovf_err set on edge where push & full & ~clr; udf_err set on edge where pop & empty & ~clr; both hold until clr or reset.
- clr: highest synchronous priority; next edge pointers=0, count=0, errors=0; push/pop ignored that cycle.
- Reset mid-operation: all state returns to reset values immediately, independent of clk; first post-reset edge behaves as from empty.
- Invariant: count == (wr_addr - rd_addr) mod DEPTH, except count==DEPTH when pointers are equal and full.

Decomposition:
- Shared package: DEPTH/AW/AF_LEVEL legal-range constants, count width constant (4), step encoding constants (HOLD, UP, DOWN).
- One sub-module: fifo_ptr (AW-bit pointer register with increment enable, sync clear, async active-low reset), instantiated twice for wr_addr and rd_addr. Count next-state uses the existing 4-bit up/down step cell driven by up/down as defined above.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with count=5 -> count=0, wr_addr=rd_addr=0, empty=1, errors=0 immediately, before next edge.
- Fill: 8 consecutive push from empty -> count 1..8, almost_full rises when count=6, full=1 at count=8, wr_addr wraps to 0; 9th push -> wr_en=0, count stays 8, ovf_err=1.
- Drain: 8 pops from full -> count 7..0, rd_addr wraps to 0, empty=1; extra pop -> rd_en=0, udf_err=1.
- Simultaneous: at count=3, push+pop for 4 cycles -> count stays 3, wr_addr and rd_addr each advance by 4 mod 8; at full, push+pop -> count 7, ovf_err=1.
- Clear priority: count=5, ovf_err=1, clr=1 with push=1 -> wr_en=0, next edge count=0, pointers=0, errors=0.
- Random push/pop for 1000 cycles -> scoreboard model matches count, addresses and flags every cycle; invariant holds.
